// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants, FSM state type and grant encoder for the demux scheduler
package demux_pkg;

    localparam int N_DEST = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } sched_state_e;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_DEST-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_DEST; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/demux_rr_scheduler_if.sv
// rtl/demux_rr_scheduler_if.sv - requester, upstream beat and demux-side signals of the scheduler
interface demux_rr_scheduler_if #(parameter int BURST_W = 4);
    import demux_pkg::*;

    logic [N_DEST-1:0]  req;
    logic [BURST_W-1:0] burst_len;
    logic               valid_in;
    logic               data_in;
    logic               ready_out;
    logic [SEL_W-1:0]   sel;
    logic               demux_in;
    logic [N_DEST-1:0]  grant;
    logic               busy;
    logic               done;

    modport master (
        output req, burst_len, valid_in, data_in,
        input  ready_out, sel, demux_in, grant, busy, done
    );

    modport slave (
        input  req, burst_len, valid_in, data_in,
        output ready_out, sel, demux_in, grant, busy, done
    );

endinterface

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - first set request at or above ptr, wrapping 7->0, as a one-hot grant
module rr_pick8
    import demux_pkg::*;
(
    input  logic [N_DEST-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [N_DEST-1:0] gnt,
    output logic              any
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        any   = |req;
        // idx is SEL_W wide, so ptr + k wraps around the eight destinations for free
        for (int k = 0; k < N_DEST; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_scheduler.sv
// rtl/demux_rr_scheduler.sv - round-robin burst scheduler driving the 1-to-8 demux select and data gate
module demux_rr_scheduler
    import demux_pkg::*;
#(
    parameter int BURST_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_rr_scheduler_if.slave   bus
);

    sched_state_e       state_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [N_DEST-1:0]  grant_q;
    logic [SEL_W-1:0]   sel_q;
    logic [BURST_W-1:0] cnt_q;
    logic [BURST_W-1:0] len_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;

    logic [N_DEST-1:0]  pick_gnt;
    logic               pick_any;
    logic [SEL_W-1:0]   sel_d;
    logic [SEL_W-1:0]   ptr_d;
    logic [BURST_W-1:0] cnt_d;
    logic [BURST_W-1:0] len_m1;
    logic               beat;
    logic               last_beat;

    rr_pick8 u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    assign sel_d  = onehot_to_idx(pick_gnt);
    assign ptr_d  = sel_q + 1'b1;
    assign cnt_d  = cnt_q + 1'b1;
    // A latched length of 0 wraps to all-ones here, giving a full 2^BURST_W beat burst
    assign len_m1    = len_q - 1'b1;
    assign beat      = bus.valid_in & ready_q;
    assign last_beat = beat & (cnt_q == len_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, GAP: begin
                    if (pick_any) begin
                        grant_q <= pick_gnt;
                        sel_q   <= sel_d;
                        len_q   <= bus.burst_len;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= XFER;
                    end else begin
                        grant_q <= '0;
                        sel_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                XFER: begin
                    if (beat) begin
                        cnt_q <= cnt_d;
                    end
                    if (last_beat) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b0;
                        ptr_q   <= ptr_d;
                        state_q <= GAP;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    grant_q <= '0;
                    sel_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_out = ready_q;
    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.demux_in  = bus.data_in & bus.valid_in & ready_q;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb/tb_demux_rr_scheduler.sv - directed self-checking bench for demux_rr_scheduler
module tb_demux_rr_scheduler;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    demux_rr_scheduler_if #(.BURST_W(4)) bus ();

    demux_rr_scheduler #(.BURST_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_g;
        logic       d;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.req       = 8'h00;
        bus.burst_len = 4'd0;
        bus.valid_in  = 1'b0;
        bus.data_in   = 1'b0;
        step();
        step();
        check("rst_grant", bus.grant, 8'h00);
        check("rst_sel", bus.sel, 3'd0);
        check("rst_ready", bus.ready_out, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        rst = 1'b0;

        // No requests: stays idle
        for (int i = 0; i < 10; i++) step();
        check("idle_grant", bus.grant, 8'h00);
        check("idle_ready", bus.ready_out, 1'b0);
        check("idle_busy", bus.busy, 1'b0);

        // Single 3-beat burst to destination 4
        bus.req = 8'h10; bus.burst_len = 4'd3; bus.valid_in = 1'b1; bus.data_in = 1'b1;
        step();
        check("b3_grant", bus.grant, 8'h10);
        check("b3_sel", bus.sel, 3'd4);
        check("b3_ready", bus.ready_out, 1'b1);
        check("b3_busy", bus.busy, 1'b1);
        check("b3_demux_in", bus.demux_in, 1'b1);
        bus.req = 8'h00;
        step();
        check("b3_beat1_done", bus.done, 1'b0);
        check("b3_beat1_ready", bus.ready_out, 1'b1);
        step();
        check("b3_beat2_done", bus.done, 1'b0);
        step();
        check("b3_gap_done", bus.done, 1'b1);
        check("b3_gap_ready", bus.ready_out, 1'b0);
        check("b3_gap_demux_in", bus.demux_in, 1'b0);
        check("b3_gap_busy", bus.busy, 1'b1);
        check("b3_gap_sel", bus.sel, 3'd4);
        step();
        check("b3_idle_grant", bus.grant, 8'h00);
        check("b3_idle_busy", bus.busy, 1'b0);
        check("b3_idle_done", bus.done, 1'b0);

        // Pointer now 5: of destinations 0 and 5, 5 wins
        bus.req = 8'h21; bus.burst_len = 4'd1;
        step();
        check("ptr5_grant", bus.grant, 8'h20);
        check("ptr5_sel", bus.sel, 3'd5);
        bus.req = 8'h00;
        step();
        check("ptr5_done", bus.done, 1'b1);
        step();
        check("ptr5_idle_busy", bus.busy, 1'b0);

        // All requesting, 1-beat bursts: 0..7 then 0, one GAP between each
        reset_pulse();
        bus.req = 8'hFF; bus.burst_len = 4'd1;
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'h01 << (k % 8);
            step();
            check("rr_xfer_grant", bus.grant, exp_g);
            check("rr_xfer_ready", bus.ready_out, 1'b1);
            step();
            check("rr_gap_done", bus.done, 1'b1);
            check("rr_gap_ready", bus.ready_out, 1'b0);
            check("rr_gap_grant", bus.grant, exp_g);
        end
        bus.req = 8'h00;
        step();
        check("rr_end_busy", bus.busy, 1'b0);
        check("rr_end_grant", bus.grant, 8'h00);

        // burst_len 0 = 16 beats with valid toggling
        bus.req = 8'h04; bus.burst_len = 4'd0; bus.valid_in = 1'b0;
        step();
        check("b16_grant", bus.grant, 8'h04);
        check("b16_sel", bus.sel, 3'd2);
        bus.req = 8'h00;
        for (int b = 0; b < 16; b++) begin
            d = 1'($urandom_range(0, 1));
            bus.valid_in = 1'b1; bus.data_in = d;
            #1;
            check("b16_demux_beat", bus.demux_in, d);
            step();
            check("b16_sel_beat", bus.sel, 3'd2);
            check("b16_done", bus.done, (b == 15) ? 1'b1 : 1'b0);
            check("b16_ready", bus.ready_out, (b == 15) ? 1'b0 : 1'b1);
            if (b < 15) begin
                bus.valid_in = 1'b0; bus.data_in = 1'b1;
                #1;
                check("b16_demux_stall", bus.demux_in, 1'b0);
                step();
                check("b16_sel_stall", bus.sel, 3'd2);
                check("b16_grant_stall", bus.grant, 8'h04);
                check("b16_done_stall", bus.done, 1'b0);
            end
        end
        bus.valid_in = 1'b1; bus.data_in = 1'b0;
        step();
        check("b16_idle_busy", bus.busy, 1'b0);

        // Asynchronous reset during beat 2 of a 5-beat burst to destination 6
        bus.req = 8'h40; bus.burst_len = 4'd5; bus.data_in = 1'b1;
        step();
        check("ar_grant", bus.grant, 8'h40);
        check("ar_sel", bus.sel, 3'd6);
        step();
        check("ar_beat1_ready", bus.ready_out, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("ar_grant0", bus.grant, 8'h00);
        check("ar_sel0", bus.sel, 3'd0);
        check("ar_ready0", bus.ready_out, 1'b0);
        check("ar_busy0", bus.busy, 1'b0);
        check("ar_demux_in0", bus.demux_in, 1'b0);
        check("ar_done0", bus.done, 1'b0);
        bus.req = 8'h41;
        step();
        rst = 1'b0;
        step();
        check("ar_after_grant", bus.grant, 8'h01);
        check("ar_after_sel", bus.sel, 3'd0);

        // Committed burst: req drop and burst_len change are ignored
        reset_pulse();
        bus.req = 8'h08; bus.burst_len = 4'd4;
        step();
        check("cm_grant", bus.grant, 8'h08);
        bus.req = 8'h00; bus.burst_len = 4'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("cm_done_early", bus.done, 1'b0);
            check("cm_sel", bus.sel, 3'd3);
            check("cm_grant_hold", bus.grant, 8'h08);
        end
        step();
        check("cm_done", bus.done, 1'b1);
        step();
        check("cm_idle_grant", bus.grant, 8'h00);
        check("cm_idle_busy", bus.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
